spi_sample_loader: RTL and testbench

- Serial front end sitting directly upstream of the FFT core inside topwrapper.
- Receives 8-bit samples over a slow SPI-style link (ss, clk_in, data_in), LSB first, and assembles NUM_SAMPLES-byte frames.
- Presents each completed frame as a stable packed sample array to the FFT, with a one-cycle frame_valid strobe.
- Double-buffered, so the FFT sees frame N while frame N+1 loads.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 41 ++++
 rtl/spi_sample_loader.sv | 164 ++++++++++++++++
 tb/tb_spi_sample_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front end: frame geometry of the
// serial sample loader and the encoding of its control states.
package fft_pkg;

    // Samples per FFT frame; must be a power of two so the byte index wraps.
    localparam int NUM_SAMPLES  = 128;
    // Bits per sample as delivered over the serial link.
    localparam int SAMPLE_W     = 8;
    // Width of an index into a frame.
    localparam int SAMPLE_IDX_W = $clog2(NUM_SAMPLES);
    // Metastability flops on each asynchronous serial input.
    localparam int SYNC_STAGES  = 2;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // IDLE: waiting for slave select; RECEIVE: shifting bytes into the working
    // buffer; COMMIT: single cycle in which a completed frame was published.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        COMMIT  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Brings one asynchronous pin into the clk domain through a flop chain and
// produces registered single-cycle rising/falling edge strobes of the
// synchronized level.
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    assign q = chain[STAGES-1];

    // Synchronizer chain plus a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop in
        // the chain samples the value its predecessor held before this edge.
        if (!n_rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
            rise <= chain[STAGES-1] & ~prev;
            fall <= ~chain[STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/spi_sample_loader.sv
// Serial sample loader feeding the FFT core. Bytes arrive LSB first on a slow
// SPI-style link, are assembled into a working frame buffer, and a completed
// frame is copied in one cycle to the samples output, which stays stable while
// the next frame loads.
module spi_sample_loader #(
    parameter int NUM_SAMPLES = fft_pkg::NUM_SAMPLES,
    parameter int SAMPLE_W    = fft_pkg::SAMPLE_W,
    parameter int SYNC_STAGES = fft_pkg::SYNC_STAGES
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 ss,
    input  logic                                 clk_in,
    input  logic                                 data_in,
    output logic [0:NUM_SAMPLES-1][SAMPLE_W-1:0] samples,
    output logic                                 frame_valid,
    output logic                                 busy,
    output logic                                 frame_abort
);

    import fft_pkg::*;

    localparam int IDX_W = $clog2(NUM_SAMPLES);
    localparam int BIT_W = $clog2(SAMPLE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SAMPLE_W - 1);

    // Synchronized serial inputs and their edge strobes.
    logic ss_q;
    logic ss_rise;
    logic ss_fall;
    logic clk_in_q;
    logic clk_in_rise;
    logic clk_in_fall_unused;
    logic [SYNC_STAGES-1:0] data_chain;
    logic data_q;

    // Loader state.
    loader_state_t                         state;
    logic [BIT_W-1:0]                      bit_cnt;
    logic [IDX_W-1:0]                      byte_cnt;
    logic [SAMPLE_W-1:0]                   shreg;
    logic                                  byte_wr;
    logic [0:NUM_SAMPLES-1][SAMPLE_W-1:0]  working;
    logic                                  bit_stb;

    sync_edge_det #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ss_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (ss),
        .q     (ss_q),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    sync_edge_det #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_clk_in_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (clk_in),
        .q     (clk_in_q),
        .rise  (clk_in_rise),
        .fall  (clk_in_fall_unused)
    );

    // Data needs no edge detection, only the same synchronizer depth so it
    // lines up with the synchronized clk_in level.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            data_chain <= '0;
        end else begin
            data_chain[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_chain[i] <= data_chain[i-1];
            end
        end
    end

    assign data_q = data_chain[SYNC_STAGES-1];

    // A bit is taken on every synchronized clk_in rise while selected; edges
    // seen with ss high or before the frame has started are ignored.
    assign bit_stb = clk_in_rise && !ss_q && (state != IDLE);

    // The pending byte write counts as progress so busy does not dip for the
    // cycle between the eighth bit of byte 0 and its write into the buffer.
    assign busy = (state == RECEIVE) && ((byte_cnt != '0) || (bit_cnt != '0) || byte_wr);

    // Byte assembly, frame buffering and the IDLE/RECEIVE/COMMIT sequencing.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            shreg       <= '0;
            byte_wr     <= 1'b0;
            // NOTE: the working buffer is cleared on reset on purpose so a
            // freshly reset loader never exposes stale bytes; this keeps it in
            // flops rather than a RAM macro, which suits this small frame.
            working     <= '0;
            samples     <= '0;
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            byte_wr     <= 1'b0;

            // LSB first: each new bit enters at the top and moves down, so
            // after SAMPLE_W strobes the first bit received sits in bit 0.
            if (bit_stb) begin
                shreg   <= {data_q, shreg[SAMPLE_W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
                byte_wr <= (bit_cnt == LAST_BIT);
            end

            // The byte is complete one cycle after its last strobe.
            if (byte_wr) begin
                working[byte_cnt] <= shreg;
                byte_cnt          <= byte_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state    <= RECEIVE;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end

                RECEIVE: begin
                    if (byte_wr && (byte_cnt == LAST_IDX)) begin
                        // Publish the frame in the same cycle the final byte
                        // lands; that byte bypasses the working buffer.
                        state                  <= COMMIT;
                        samples                <= working;
                        samples[NUM_SAMPLES-1] <= shreg;
                        frame_valid            <= 1'b1;
                    end else if (ss_rise) begin
                        state <= IDLE;
                        if ((byte_cnt != '0) || (bit_cnt != '0) || byte_wr) begin
                            frame_abort <= 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    // Counters already wrapped to zero, so a strobe taken in
                    // this cycle simply starts the next frame.
                    state <= ss_q ? IDLE : RECEIVE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sample_loader.sv
// Directed plus randomized bench for spi_sample_loader. A byte-list model of
// the link predicts the committed frame and the frame_valid/frame_abort counts.
module tb_spi_sample_loader;

    import fft_pkg::*;

    localparam int N = NUM_SAMPLES;
    localparam int W = SAMPLE_W;

    logic clk     = 1'b0;
    logic n_rst   = 1'b0;
    logic ss      = 1'b1;
    logic clk_in  = 1'b1;
    logic data_in = 1'b0;
    logic [0:N-1][W-1:0] samples;
    logic frame_valid;
    logic busy;
    logic frame_abort;

    spi_sample_loader dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .ss          (ss),
        .clk_in      (clk_in),
        .data_in     (data_in),
        .samples     (samples),
        .frame_valid (frame_valid),
        .busy        (busy),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Observation of the DUT's pulses.
    int cyc            = 0;
    int vcnt           = 0;
    int acnt           = 0;
    int both_cnt       = 0;
    int bad_change     = 0;
    int last_valid_cyc = -1;
    int last_rise_cyc  = 0;
    bit mon_en         = 1'b0;
    logic [0:N-1][W-1:0] prev_samples;

    // Reference model: bytes of the frame in flight and the last full frame.
    logic [W-1:0]        sent[$];
    logic [0:N-1][W-1:0] exp_frame;
    int exp_vcnt = 0;
    int exp_acnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_valid) begin
            vcnt++;
            last_valid_cyc = cyc;
        end
        if (frame_abort) acnt++;
        if (frame_valid && frame_abort) both_cnt++;
        if (mon_en && !frame_valid && (samples !== prev_samples)) bad_change++;
        prev_samples = samples;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < N; i++) begin
            if (samples[i] !== exp_frame[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_frame(input string tag);
        int idx;
        idx = first_diff();
        tests++;
        assert (samples === exp_frame) else begin
            errors++;
            $error("FAIL %s: samples[%0d] observed %0h expected %0h",
                   tag, idx, samples[idx], exp_frame[idx]);
        end
    endtask

    task automatic model_push(input logic [W-1:0] v);
        sent.push_back(v);
        if (sent.size() == N) begin
            for (int i = 0; i < N; i++) exp_frame[i] = sent[i];
            sent.delete();
            exp_vcnt++;
        end
    endtask

    task automatic model_ss_rise(input int extra_bits);
        if (sent.size() != 0 || extra_bits != 0) exp_acnt++;
        sent.delete();
    endtask

    // One bit cell: clk_in low for 'half' cycles with data set up, then high.
    task automatic send_bit(input logic b, input int half);
        clk_in  = 1'b0;
        data_in = b;
        repeat (half) @(negedge clk);
        clk_in        = 1'b1;
        last_rise_cyc = cyc;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_byte(input logic [W-1:0] v, input int half);
        for (int i = 0; i < W; i++) send_bit(v[i], half);
        model_push(v);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a_rise;
        int b_rise;
        int busy_hi;
        logic [W-1:0] v;

        exp_frame = '0;

        // Reset with the link idle.
        wait_cycles(3);
        check("reset_frame_valid", frame_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_abort", frame_abort, 0);
        check_frame("reset_samples");
        n_rst  = 1'b1;
        wait_cycles(2);
        mon_en = 1'b1;

        // Frame A: all 0xFF.
        ss = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < N; i++) send_byte(8'hFF, 4);
        a_rise = last_rise_cyc;

        // Frame B begins immediately; check A while B's first byte is done.
        send_byte(8'hFF, 4);
        check("frame_a_count", vcnt, exp_vcnt);
        check("frame_a_latency", last_valid_cyc - a_rise, 5);
        check_frame("frame_a_samples");
        for (int i = 1; i < N; i++) send_byte(8'h00, 4);
        b_rise = last_rise_cyc;
        ss = 1'b1;
        model_ss_rise(0);
        wait_cycles(12);
        check("frame_b_count", vcnt, exp_vcnt);
        check("frame_b_latency", last_valid_cyc - b_rise, 5);
        check("boundary_no_abort", acnt, exp_acnt);
        check_frame("frame_b_samples");
        check("frame_b_s0", samples[0], 8'hFF);
        check("frame_b_s1", samples[1], 8'h00);
        check("frame_b_idle_busy", busy, 0);

        // Frame C ascending, then frame D with a bit-order pattern and random tail.
        ss = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < N; i++) send_byte(W'(i), 4);
        wait_cycles(12);
        check("frame_c_count", vcnt, exp_vcnt);
        check_frame("frame_c_samples");
        send_byte(8'h01, 4);
        send_byte(8'h80, 4);
        send_byte(8'hA5, 4);
        for (int i = 3; i < N; i++) send_byte(W'($urandom), 4);
        wait_cycles(12);
        check("frame_d_count", vcnt, exp_vcnt);
        check_frame("frame_d_samples");
        check("frame_d_s2", samples[2], 8'hA5);
        ss = 1'b1;
        model_ss_rise(0);
        wait_cycles(8);

        // Abort after 37 bytes and 3 bits.
        ss = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < 37; i++) send_byte(W'($urandom), 4);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 4);
        check("abort_busy_before", busy, 1);
        ss = 1'b1;
        model_ss_rise(3);
        wait_cycles(12);
        check("abort_count", acnt, exp_acnt);
        check("abort_no_valid", vcnt, exp_vcnt);
        check("abort_busy_after", busy, 0);
        check_frame("abort_samples_kept");

        // Frame E random data, random bit-cell timing.
        ss = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < N; i++) begin
            v = W'($urandom);
            send_byte(v, int'($urandom_range(6, 4)));
        end
        wait_cycles(12);
        check("frame_e_count", vcnt, exp_vcnt);
        check("frame_e_no_abort", acnt, exp_acnt);
        check_frame("frame_e_samples");
        ss = 1'b1;
        model_ss_rise(0);
        wait_cycles(8);

        // Reset in the middle of byte 60 of a new frame.
        ss = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < 60; i++) send_byte(W'($urandom), 4);
        check("pre_reset_busy", busy, 1);
        mon_en = 1'b0;
        n_rst  = 1'b0;
        ss     = 1'b1;
        sent.delete();
        exp_frame = '0;
        wait_cycles(1);
        check_frame("mid_reset_samples");
        check("mid_reset_busy", busy, 0);
        check("mid_reset_frame_valid", frame_valid, 0);
        check("mid_reset_frame_abort", frame_abort, 0);
        n_rst = 1'b1;
        wait_cycles(3);
        mon_en = 1'b1;

        // clk_in activity with ss high must be ignored.
        busy_hi = 0;
        for (int i = 0; i < 16; i++) begin
            clk_in  = 1'b0;
            data_in = 1'($urandom);
            repeat (4) begin
                @(negedge clk);
                if (busy) busy_hi++;
            end
            clk_in = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (busy) busy_hi++;
            end
        end
        wait_cycles(8);
        check("ss_high_busy_cycles", busy_hi, 0);
        check("post_reset_valid_count", vcnt, exp_vcnt);
        check("post_reset_abort_count", acnt, exp_acnt);
        check_frame("post_reset_samples");

        check("valid_abort_overlap", both_cnt, 0);
        check("samples_changed_without_valid", bad_change, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
